// File: rtl/sm_regdump_if.sv
// Output stream of the register dump engine: valid/ready word with index and last markers.
interface sm_regdump_if;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_idx;
   logic        out_last;

   modport master (output out_valid, out_data, out_idx, out_last, input out_ready);
   modport slave  (input out_valid, out_data, out_idx, out_last, output out_ready);
endinterface

// File: rtl/sm_regdump.sv
// Register-file dump engine: freezes the CPU, walks regAddr 0..NREGS-1 and
// streams each settled regData sample as a registered word.
module sm_regdump #(
   parameter int NREGS  = 32,
   parameter int SETTLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        cpu_hold_o,
   output logic [4:0]  regAddr_o,
   input  logic [31:0] regData_i,
   sm_regdump_if.master dump
);
   localparam int             CW       = $clog2(SETTLE + 1);
   localparam logic [CW-1:0]  CNT_INIT = CW'(SETTLE - 1);
   localparam logic [4:0]     LAST_IDX = 5'(NREGS - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    idx_q, idx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          valid_q, valid_d;
   logic [31:0]   data_q, data_d;
   logic [4:0]    oidx_q, oidx_d;
   logic          last_q, last_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         oidx_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         oidx_q  <= oidx_d;
         last_q  <= last_d;
      end
   end

   // HOLD always has out_valid high, so out_ready alone marks the handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start_i) state_d = S_SETTLE;
         S_SETTLE: if (cnt_q == '0) state_d = S_HOLD;
         S_HOLD:   if (dump.out_ready) state_d = last_q ? S_IDLE : S_SETTLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      data_d  = data_q;
      oidx_d  = oidx_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               idx_d  = '0;
               cnt_d  = CNT_INIT;
               busy_d = 1'b1;
            end
         end
         S_SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               data_d  = regData_i;
               oidx_d  = idx_q;
               last_d  = (idx_q == LAST_IDX);
               valid_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (dump.out_ready) begin
               valid_d = 1'b0;
               if (last_q) begin
                  busy_d = 1'b0;
                  done_d = 1'b1;
               end else begin
                  idx_d = idx_q + 5'd1;
                  cnt_d = CNT_INIT;
               end
            end
         end
         default: ;
      endcase
   end

   assign busy_o         = busy_q;
   assign cpu_hold_o     = busy_q;
   assign done_o         = done_q;
   assign regAddr_o      = idx_q;
   assign dump.out_valid = valid_q;
   assign dump.out_data  = data_q;
   assign dump.out_idx   = oidx_q;
   assign dump.out_last  = last_q;
endmodule

// File: tb/tb_sm_regdump.sv
// Bench for sm_regdump: two configurations (32x1, 4x3) against a word-queue model of the dump.
module tb_sm_regdump;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, ready, disturb, sel;
   logic [31:0] rf [32];
   logic [31:0] pc;
   int          total = 0;
   int          bad   = 0;

   sm_regdump_if ifa ();
   sm_regdump_if ifb ();

   logic        busy_a, done_a, hold_a, busy_b, done_b, hold_b;
   logic [4:0]  addr_a, addr_b;
   logic [31:0] rd_a, rd_b;
   logic        start_a, start_b;

   assign ifa.out_ready = ready;
   assign ifb.out_ready = ready;
   assign start_a = start & ~sel;
   assign start_b = start & sel;
   // Corrupt regData while a word is held so a non-snapshot output would be caught.
   assign rd_a = rf[addr_a] ^ ((disturb && ifa.out_valid) ? 32'hDEADBEEF : 32'h0);
   assign rd_b = rf[addr_b] ^ ((disturb && ifb.out_valid) ? 32'hDEADBEEF : 32'h0);

   sm_regdump #(.NREGS(32), .SETTLE(1)) u_a (
      .clk(clk), .rst(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
      .cpu_hold_o(hold_a), .regAddr_o(addr_a), .regData_i(rd_a), .dump(ifa));
   sm_regdump #(.NREGS(4), .SETTLE(3)) u_b (
      .clk(clk), .rst(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
      .cpu_hold_o(hold_b), .regAddr_o(addr_b), .regData_i(rd_b), .dump(ifb));

   logic        c_valid, c_last, c_busy, c_done, c_hold;
   logic [31:0] c_data;
   logic [4:0]  c_idx, c_addr;
   assign c_valid = sel ? ifb.out_valid : ifa.out_valid;
   assign c_last  = sel ? ifb.out_last  : ifa.out_last;
   assign c_data  = sel ? ifb.out_data  : ifa.out_data;
   assign c_idx   = sel ? ifb.out_idx   : ifa.out_idx;
   assign c_busy  = sel ? busy_b : busy_a;
   assign c_done  = sel ? done_b : done_a;
   assign c_hold  = sel ? hold_b : hold_a;
   assign c_addr  = sel ? addr_b : addr_a;

   // Stand-in CPU: pc advances on every clock the dump engine does not hold it.
   always @(posedge clk) begin
      if (rst) pc <= 32'd0;
      else if (!c_hold) pc <= pc + 32'd1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      int n; int s; int rmode; int pulses; int dis;
      int exp_words; int exp_done;
   } vec_t;

   task automatic run_dump(input vec_t v);
      logic [31:0] qd[$];
      int          qi[$];
      int          hs = 0, ndone = 0, done_cyc = -1, cyc = 0;
      logic        stall = 1'b0, sv_last = 1'b0;
      logic [31:0] sv_data = '0, pc0, pc_done = '0, ed;
      logic [4:0]  sv_idx = '0;
      sel = (v.n == 4);
      disturb = v.dis[0];
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf[0]  = 32'h0;
      rf[10] = 32'h0000002A;
      for (int i = 0; i < v.n; i++) begin qd.push_back(rf[i]); qi.push_back(i); end
      @(negedge clk); start = 1'b1; ready = 1'b0;
      @(negedge clk); start = 1'b0;
      chk("start_busy", {31'd0, c_busy}, 32'd1);
      chk("start_addr", {27'd0, c_addr}, 32'd0);
      pc0 = pc;
      while (cyc < 3000) begin
         if (done_cyc >= 0 && cyc == done_cyc + 3) begin
            chk("pc_resume", pc, pc_done + 32'd3);
            break;
         end
         chk("hold_eq_busy", {31'd0, c_hold}, {31'd0, c_busy});
         if (stall) begin
            chk("stall_valid", {31'd0, c_valid}, 32'd1);
            chk("stall_data", c_data, sv_data);
            chk("stall_idx", {27'd0, c_idx}, {27'd0, sv_idx});
            chk("stall_last", {31'd0, c_last}, {31'd0, sv_last});
         end
         if (c_done) begin
            ndone++;
            if (done_cyc < 0) begin done_cyc = cyc; pc_done = pc; end
         end
         chk("busy_level", {31'd0, c_busy}, (done_cyc >= 0) ? 32'd0 : 32'd1);
         start = (v.pulses != 0) && (cyc == 5 || cyc == 20);
         ready = (v.rmode != 0) ? ($urandom_range(0, 2) == 0) : 1'b1;
         if (c_valid && ready) begin
            if (qd.size() == 0) begin
               chk("extra_word", {27'd0, c_idx}, 32'hFFFF_FFFF);
            end else begin
               chk("word_data", c_data, qd[0]);
               chk("word_idx", {27'd0, c_idx}, qi[0]);
               chk("word_last", {31'd0, c_last}, (qi[0] == v.n - 1) ? 32'd1 : 32'd0);
               void'(qd.pop_front());
               void'(qi.pop_front());
            end
            hs++;
         end
         stall = c_valid && !ready;
         sv_data = c_data; sv_idx = c_idx; sv_last = c_last;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk("handshakes", hs, v.exp_words);
      chk("done_pulses", ndone, 32'd1);
      chk("pc_frozen", pc_done, pc0);
      ed = v.exp_done;
      if (v.exp_done >= 0) chk("done_cycle", done_cyc, ed);
   endtask

   vec_t vt[5];

   initial begin
      rst = 1'b1; start = 1'b0; ready = 1'b0; disturb = 1'b0; sel = 1'b0;
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 50; c++) begin
         chk("idle_ctl_a", {17'd0, busy_a, done_a, hold_a, ifa.out_valid, ifa.out_last, addr_a, ifa.out_idx}, 32'd0);
         chk("idle_data_a", ifa.out_data, 32'd0);
         chk("idle_ctl_b", {17'd0, busy_b, done_b, hold_b, ifb.out_valid, ifb.out_last, addr_b, ifb.out_idx}, 32'd0);
         chk("idle_data_b", ifb.out_data, 32'd0);
         @(negedge clk);
      end

      vt[0] = '{32, 1, 0, 0, 0, 32, 64};
      vt[1] = '{32, 1, 1, 0, 1, 32, -1};
      vt[2] = '{32, 1, 0, 1, 0, 32, 64};
      vt[3] = '{4,  3, 0, 0, 0, 4,  16};
      vt[4] = '{4,  3, 1, 0, 1, 4,  -1};
      for (int k = 0; k < 5; k++) run_dump(vt[k]);

      // Reset while word 12 is being held: dump abandoned, no done, then a clean full dump.
      begin
         int found = 0;
         sel = 1'b0; disturb = 1'b0;
         @(negedge clk); start = 1'b1; ready = 1'b1;
         @(negedge clk); start = 1'b0;
         for (int c = 0; c < 500; c++) begin
            if (c_valid && c_idx == 5'd12) begin found = 1; ready = 1'b0; break; end
            ready = 1'b1;
            @(negedge clk);
         end
         chk("rst_reach_idx12", found, 32'd1);
         rst = 1'b1;
         @(negedge clk);
         chk("rst_valid", {31'd0, c_valid}, 32'd0);
         chk("rst_busy", {31'd0, c_busy}, 32'd0);
         chk("rst_done", {31'd0, c_done}, 32'd0);
         rst = 1'b0;
         for (int c = 0; c < 10; c++) begin
            chk("rst_no_done", {31'd0, c_done | c_busy}, 32'd0);
            @(negedge clk);
         end
         run_dump(vt[0]);
      end

      for (int k = 0; k < 4; k++) begin
         vec_t r;
         r.n = ($urandom_range(0, 1) == 0) ? 32 : 4;
         r.s = (r.n == 4) ? 3 : 1;
         r.rmode = $urandom_range(0, 1);
         r.pulses = 0;
         r.dis = $urandom_range(0, 1);
         r.exp_words = r.n;
         r.exp_done = (r.rmode == 0) ? r.n * (r.s + 1) : -1;
         run_dump(r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
